// File: rtl/l2_req_sched_pkg.sv
// Shared widths, tag-table entry type and small helpers for the L2 request scheduler.
package l2_req_sched_pkg;

  localparam int NSTREAMS = 8;
  localparam int L2_NCL   = 256;
  localparam int NTAGS    = 32;
  localparam int SID_W    = $clog2(NSTREAMS);
  localparam int CLID_W   = $clog2(L2_NCL);
  localparam int TAG_W    = $clog2(NTAGS);

  typedef logic [SID_W-1:0]  sid_t;
  typedef logic [CLID_W-1:0] clid_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef struct packed {
    sid_t  sid;
    clid_t clid;
  } tag_entry_t;

  function automatic logic [NSTREAMS-1:0] sid_onehot(input sid_t s);
    logic [NSTREAMS-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/l2_req_sched_if.sv
// Stream-side, OpenCAPI-side and L2-write-side handshakes of the request scheduler.
interface l2_req_sched_if;
  import l2_req_sched_pkg::*;

  logic [NSTREAMS-1:0] i_req_v;
  logic [NSTREAMS-1:0] i_req_r;
  logic [NSTREAMS-1:0] i_rst_v;

  logic                o_req_v;
  logic                o_req_r;
  sid_t                o_req_sid;
  clid_t               o_req_clid;
  tag_t                o_req_tag;

  logic                i_rsp_v;
  logic                i_rsp_r;
  tag_t                i_rsp_tag;

  logic                o_wr_v;
  logic                o_wr_r;
  sid_t                o_wr_sid;
  clid_t               o_wr_clid;

  logic [NSTREAMS-1:0] o_rsp_v;
  logic                o_err;

  modport slave (
    input  i_req_v, i_rst_v, o_req_r, i_rsp_v, i_rsp_tag, o_wr_r,
    output i_req_r, o_req_v, o_req_sid, o_req_clid, o_req_tag,
           i_rsp_r, o_wr_v, o_wr_sid, o_wr_clid, o_rsp_v, o_err
  );

  modport master (
    output i_req_v, i_rst_v, o_req_r, i_rsp_v, i_rsp_tag, o_wr_r,
    input  i_req_r, o_req_v, o_req_sid, o_req_clid, o_req_tag,
           i_rsp_r, o_wr_v, o_wr_sid, o_wr_clid, o_rsp_v, o_err
  );

endinterface

// File: rtl/l2_req_sched_rr_arb.sv
// NSTREAMS-way round-robin arbiter: combinational one-hot grant when en_i, pointer moves past winner.
// Zero latency from req_i to gnt_o; no grant at all while en_i is low.
module l2_req_sched_rr_arb
  import l2_req_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [NSTREAMS-1:0] req_i,
  output logic [NSTREAMS-1:0] gnt_o,
  output logic                gnt_vld_o,
  output sid_t                gnt_sid_o
);

  sid_t ptr_q, ptr_d;
  sid_t idx;
  logic found;
  sid_t win;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NSTREAMS; k++) begin
      idx = sid_t'((int'(ptr_q) + k) % NSTREAMS);
      if (en_i && !found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = found;
    gnt_sid_o = win;
    if (found) gnt_o[win] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (win == sid_t'(NSTREAMS - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/l2_req_sched.sv
// Shares one OpenCAPI read-request channel among NSTREAMS streams; tags map responses to L2 writes.
// Request: 1-cycle registered stage, held until o_req_r; response-to-write path is combinational.
module l2_req_sched
  import l2_req_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  l2_req_sched_if.slave bus
);

  logic [NTAGS-1:0] busy_q, busy_d;
  tag_entry_t       tag_q  [NTAGS];
  tag_entry_t       tag_d  [NTAGS];
  clid_t            fill_q [NSTREAMS];
  clid_t            fill_d [NSTREAMS];
  logic             err_q, err_d;
  logic             out_vld_q, out_vld_d;
  sid_t             out_sid_q, out_sid_d;
  clid_t            out_clid_q, out_clid_d;
  tag_t             out_tag_q, out_tag_d;

  tag_t                free_tag;
  logic                any_free;
  logic                arb_en;
  logic [NSTREAMS-1:0] gnt;
  logic                gnt_vld;
  sid_t                gnt_sid;
  tag_entry_t          rsp_ent;
  logic                rsp_busy;
  logic                wr_fire;

  // Lowest free tag, taken from the registered bitmap so a tag freed this cycle is not reused until next.
  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_tag = tag_t'(i);
        any_free = 1'b1;
      end
    end
  end

  assign arb_en = (~out_vld_q | bus.o_req_r) & any_free;

  // A stream being functionally reset is masked so its fill counter clear is never lost to a grant.
  l2_req_sched_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (arb_en),
    .req_i     (bus.i_req_v & ~bus.i_rst_v),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld),
    .gnt_sid_o (gnt_sid)
  );

  assign bus.i_req_r = gnt;

  assign rsp_ent  = tag_q[bus.i_rsp_tag];
  assign rsp_busy = busy_q[bus.i_rsp_tag];
  assign wr_fire  = bus.o_wr_v & bus.o_wr_r;

  assign bus.o_wr_v    = bus.i_rsp_v & rsp_busy;
  assign bus.o_wr_sid  = rsp_ent.sid;
  assign bus.o_wr_clid = rsp_ent.clid;
  assign bus.i_rsp_r   = bus.o_wr_r | ~rsp_busy;
  assign bus.o_rsp_v   = wr_fire ? sid_onehot(rsp_ent.sid) : '0;

  assign bus.o_req_v    = out_vld_q;
  assign bus.o_req_sid  = out_sid_q;
  assign bus.o_req_clid = out_clid_q;
  assign bus.o_req_tag  = out_tag_q;
  assign bus.o_err      = err_q;

  always_comb begin
    busy_d     = busy_q;
    tag_d      = tag_q;
    fill_d     = fill_q;
    err_d      = err_q | (bus.i_rsp_v & ~rsp_busy);
    out_vld_d  = out_vld_q & ~bus.o_req_r;
    out_sid_d  = out_sid_q;
    out_clid_d = out_clid_q;
    out_tag_d  = out_tag_q;

    // Freed and allocated tags never coincide: allocation only picks tags idle in busy_q.
    if (wr_fire) busy_d[bus.i_rsp_tag] = 1'b0;

    if (gnt_vld) begin
      busy_d[free_tag] = 1'b1;
      tag_d[free_tag]  = '{sid: gnt_sid, clid: fill_q[gnt_sid]};
      fill_d[gnt_sid]  = fill_q[gnt_sid] + 1'b1;
      out_vld_d        = 1'b1;
      out_sid_d        = gnt_sid;
      out_clid_d       = fill_q[gnt_sid];
      out_tag_d        = free_tag;
    end

    for (int s = 0; s < NSTREAMS; s++) begin
      if (bus.i_rst_v[s]) fill_d[s] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      err_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_sid_q  <= '0;
      out_clid_q <= '0;
      out_tag_q  <= '0;
      for (int i = 0; i < NTAGS; i++)    tag_q[i]  <= '0;
      for (int s = 0; s < NSTREAMS; s++) fill_q[s] <= '0;
    end else begin
      busy_q     <= busy_d;
      err_q      <= err_d;
      out_vld_q  <= out_vld_d;
      out_sid_q  <= out_sid_d;
      out_clid_q <= out_clid_d;
      out_tag_q  <= out_tag_d;
      for (int i = 0; i < NTAGS; i++)    tag_q[i]  <= tag_d[i];
      for (int s = 0; s < NSTREAMS; s++) fill_q[s] <= fill_d[s];
    end
  end

endmodule
